gram_init_sequencer: RTL and testbench



---
 rtl/gram_init_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_gram_init_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gram_init_sequencer.sv
// gram_init_sequencer
//   Hardware DDR3 bring-up for the gram SoC. A Wishbone master walks a fixed
//   table of 29 DFII register writes (reset release, CKE, MR2/MR3/MR1/MR0,
//   ZQCL, hand-over to the controller) with wait intervals between them.
//
// Ports
//   clk, rst      : system clock, synchronous active-high reset
//   start         : one-cycle pulse, starts the sequence from IDLE/DONE/ERROR
//   wb_adr        : Wishbone word address (DFII_BASE + register offset)
//   wb_dat_w      : write data (zero-extended table value)
//   wb_sel        : byte select, 4'hF during a cycle
//   wb_cyc/wb_stb : bus cycle / strobe
//   wb_we         : write enable, 1 during a cycle
//   wb_ack        : slave acknowledge
//   busy          : sequence in progress
//   done          : sequence completed, held until next start or rst
//   error         : ack timeout, held until next start or rst
//   step          : index of current or last table entry (0..28)
module gram_init_sequencer #(
    parameter logic [31:0] DFII_BASE     = 32'h0000_2400,
    parameter logic [13:0] MR0           = 14'h220,
    parameter logic [13:0] MR1           = 14'h006,
    parameter logic [13:0] MR2           = 14'h200,
    parameter logic [13:0] MR3           = 14'h000,
    parameter int unsigned RESET_WAIT    = 35,
    parameter int unsigned DLLK_WAIT     = 600,
    parameter int unsigned ZQ_WAIT       = 600,
    parameter int unsigned HANDOVER_WAIT = 200,
    parameter int unsigned ACK_TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_w,
    output logic [3:0]  wb_sel,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    input  logic        wb_ack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [4:0]  step
);

    localparam int unsigned MAX_A    = (RESET_WAIT > DLLK_WAIT) ? RESET_WAIT : DLLK_WAIT;
    localparam int unsigned MAX_B    = (ZQ_WAIT > HANDOVER_WAIT) ? ZQ_WAIT : HANDOVER_WAIT;
    localparam int unsigned MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int unsigned TO_W     = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [4:0]  LAST_STEP = 5'd28;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_REQ,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        step_q, step_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic              post_q, post_d;   // current WAIT is the post-wait of step_q

    logic [2:0]        ent_off;
    logic [13:0]       ent_val;
    logic [CNT_W-1:0]  ent_wait;
    logic [13:0]       mr_val;
    logic [13:0]       mr_ba;

    // Table lookup. Entries 4..27 are six groups of four writes
    // (address, baddress, command, issue); step[4:2] selects the group.
    always_comb begin
        ent_off  = 3'd0;
        ent_val  = '0;
        ent_wait = '0;
        mr_val   = '0;
        mr_ba    = '0;
        case (step_q[4:2])
            3'd1:    begin mr_val = MR2;            mr_ba = 14'd2; end
            3'd2:    begin mr_val = MR3;            mr_ba = 14'd3; end
            3'd3:    begin mr_val = MR1;            mr_ba = 14'd1; end
            3'd4:    begin mr_val = MR0 | 14'h100;  mr_ba = 14'd0; end
            3'd5:    begin mr_val = MR0;            mr_ba = 14'd0; end
            3'd6:    begin mr_val = 14'h400;        mr_ba = 14'd0; end
            default: ;
        endcase
        if (step_q < 5'd4) begin
            case (step_q[1:0])
                2'd0:    begin ent_off = 3'd3; ent_val = 14'h000; end
                2'd1:    begin ent_off = 3'd4; ent_val = 14'h000; end
                2'd2:    begin ent_off = 3'd0; ent_val = 14'h00C; end
                default: begin ent_off = 3'd0; ent_val = 14'h00E; end
            endcase
        end else if (step_q == LAST_STEP) begin
            ent_off  = 3'd0;
            ent_val  = 14'h001;
            ent_wait = CNT_W'(HANDOVER_WAIT);
        end else begin
            case (step_q[1:0])
                2'd0:    begin ent_off = 3'd3; ent_val = mr_val; end
                2'd1:    begin ent_off = 3'd4; ent_val = mr_ba; end
                2'd2:    begin ent_off = 3'd1; ent_val = (step_q[4:2] == 3'd6) ? 14'h003 : 14'h00F; end
                default: begin ent_off = 3'd2; ent_val = 14'h001; end
            endcase
            if (step_q == 5'd23) ent_wait = CNT_W'(DLLK_WAIT);
            if (step_q == 5'd27) ent_wait = CNT_W'(ZQ_WAIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            post_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            post_q  <= post_d;
        end
    end

    // Post-waits are measured from the ack edge: the GAP cycle is the first
    // idle cycle of the wait, so WAIT is loaded with (wait - 2) and a wait of
    // 0 or 1 collapses into the mandatory single GAP cycle.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        post_d  = post_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    step_d = '0;
                    post_d = 1'b0;
                    tcnt_d = '0;
                    if (RESET_WAIT == 0) begin
                        state_d = S_REQ;
                    end else begin
                        cnt_d   = CNT_W'(RESET_WAIT - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    post_d = 1'b0;
                    tcnt_d = '0;
                    if (!post_q) begin
                        state_d = S_REQ;
                    end else if (step_q == LAST_STEP) begin
                        state_d = S_DONE;
                    end else begin
                        step_d  = step_q + 5'd1;
                        state_d = S_REQ;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_REQ: begin
                if (wb_ack) begin
                    state_d = S_GAP;
                end else if (tcnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            S_GAP: begin
                if (ent_wait > CNT_W'(1)) begin
                    cnt_d   = ent_wait - CNT_W'(2);
                    post_d  = 1'b1;
                    state_d = S_WAIT;
                end else if (step_q == LAST_STEP) begin
                    state_d = S_DONE;
                end else begin
                    step_d  = step_q + 5'd1;
                    tcnt_d  = '0;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic in_req;
    assign in_req   = (state_q == S_REQ);
    assign wb_cyc   = in_req;
    assign wb_stb   = in_req;
    assign wb_we    = in_req;
    assign wb_sel   = in_req ? 4'hF : 4'h0;
    assign wb_adr   = in_req ? (DFII_BASE + {29'd0, ent_off}) : '0;
    assign wb_dat_w = in_req ? {18'd0, ent_val} : '0;
    assign busy     = (state_q == S_WAIT) || (state_q == S_REQ) || (state_q == S_GAP);
    assign done     = (state_q == S_DONE);
    assign error    = (state_q == S_ERROR);
    assign step     = step_q;

endmodule

// File: tb/tb_gram_init_sequencer.sv
// tb_gram_init_sequencer
//   Randomised scoreboard bench for gram_init_sequencer. A reference model
//   builds the 29-entry write table and a cycle schedule from the sequence
//   rules; the stimulus side pushes expected writes into a queue, a monitor
//   pops and compares on every acknowledged Wishbone write.
module tb_gram_init_sequencer;

    localparam logic [31:0] DFII_BASE     = 32'h0000_2400;
    localparam int unsigned MR0           = 'h220;
    localparam int unsigned MR1           = 'h006;
    localparam int unsigned MR2           = 'h200;
    localparam int unsigned MR3           = 'h000;
    localparam int unsigned RESET_WAIT    = 35;
    localparam int unsigned DLLK_WAIT     = 600;
    localparam int unsigned ZQ_WAIT       = 600;
    localparam int unsigned HANDOVER_WAIT = 200;
    localparam int unsigned ACK_TIMEOUT   = 255;
    localparam int          N_ENT         = 29;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [3:0]  wb_sel;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic        wb_ack;
    logic        busy;
    logic        done;
    logic        error;
    logic [4:0]  step;

    always #5 clk = ~clk;

    gram_init_sequencer #(
        .DFII_BASE    (DFII_BASE),
        .MR0          (14'(MR0)),
        .MR1          (14'(MR1)),
        .MR2          (14'(MR2)),
        .MR3          (14'(MR3)),
        .RESET_WAIT   (RESET_WAIT),
        .DLLK_WAIT    (DLLK_WAIT),
        .ZQ_WAIT      (ZQ_WAIT),
        .HANDOVER_WAIT(HANDOVER_WAIT),
        .ACK_TIMEOUT  (ACK_TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .wb_adr  (wb_adr),
        .wb_dat_w(wb_dat_w),
        .wb_sel  (wb_sel),
        .wb_cyc  (wb_cyc),
        .wb_stb  (wb_stb),
        .wb_we   (wb_we),
        .wb_ack  (wb_ack),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .step    (step)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        int          idx;
        longint      ack_cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned tbl_off[N_ENT];
    int unsigned tbl_val[N_ENT];
    int unsigned tbl_wait[N_ENT];
    int          n_tests = 0;
    int          n_fail  = 0;
    longint      cyc_n   = 0;
    longint      pred_done;
    longint      pred_err;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // ---------------- reference model: the write table ----------------
    function automatic void build_table();
        int unsigned a, ba, cmd, b;
        tbl_off[0] = 3; tbl_val[0] = 0;
        tbl_off[1] = 4; tbl_val[1] = 0;
        tbl_off[2] = 0; tbl_val[2] = 'h0C;
        tbl_off[3] = 0; tbl_val[3] = 'h0E;
        for (int g = 0; g < 6; g++) begin
            cmd = 'h0F;
            case (g)
                0: begin a = MR2;          ba = 2; end
                1: begin a = MR3;          ba = 3; end
                2: begin a = MR1;          ba = 1; end
                3: begin a = MR0 | 'h100;  ba = 0; end
                4: begin a = MR0;          ba = 0; end
                default: begin a = 'h400;  ba = 0; cmd = 'h03; end
            endcase
            b = 4 + 4 * g;
            tbl_off[b]   = 3; tbl_val[b]   = a;
            tbl_off[b+1] = 4; tbl_val[b+1] = ba;
            tbl_off[b+2] = 1; tbl_val[b+2] = cmd;
            tbl_off[b+3] = 2; tbl_val[b+3] = 1;
        end
        tbl_off[28] = 0; tbl_val[28] = 'h01;
        for (int i = 0; i < N_ENT; i++) tbl_wait[i] = 0;
        tbl_wait[23] = DLLK_WAIT;
        tbl_wait[27] = ZQ_WAIT;
        tbl_wait[28] = HANDOVER_WAIT;
    endfunction

    // ---------------- slave ----------------
    int unsigned slave_lat = 0;
    int          ack_block = -1;   // transaction index the slave never acks
    int          n_acked   = 0;
    int          ack_base  = 0;
    int unsigned lat_cnt   = 0;
    logic        ack_q     = 1'b0;
    logic        ack_force = 1'b0;
    logic        slave_ok;

    assign slave_ok = wb_cyc && wb_stb && !((ack_block >= 0) && ((n_acked - ack_base) == ack_block));
    assign wb_ack   = ack_force | ((slave_lat == 0) ? slave_ok : ack_q);

    always @(posedge clk) begin
        if (wb_cyc && wb_stb && wb_ack) n_acked <= n_acked + 1;
        if (slave_ok && !wb_ack) begin
            lat_cnt <= lat_cnt + 1;
            ack_q   <= ((lat_cnt + 1) == slave_lat);
        end else begin
            lat_cnt <= 0;
            ack_q   <= 1'b0;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && wb_cyc) begin
            if (sb.size() == 0) begin
                if (wb_ack) check("unexpected_write", wb_adr, 0);
            end else begin
                check("adr", wb_adr, sb[0].adr);
                check("dat", wb_dat_w, sb[0].dat);
                check("sel", wb_sel, 4'hF);
                check("we_stb", {wb_we, wb_stb}, 2'b11);
                if (wb_ack) begin
                    check("ack_cycle", cyc_n, sb[0].ack_cyc);
                    check("ack_step", step, sb[0].idx);
                    case (sb[0].idx)
                        2:  check("spot_w2",  {wb_adr, wb_dat_w}, {32'h2400, 32'h0C});
                        16: check("spot_w16", {wb_adr, wb_dat_w}, {32'h2403, 32'h320});
                        20: check("spot_w20", wb_dat_w, 32'h220);
                        24: check("spot_w24", {wb_adr, wb_dat_w}, {32'h2403, 32'h400});
                        28: check("spot_w28", {wb_adr, wb_dat_w}, {32'h2400, 32'h01});
                        default: ;
                    endcase
                    void'(sb.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Issue start and push the whole expected schedule. Each write occupies
    // lat+1 cycles; the next one begins after max(1, post-wait) idle cycles.
    task automatic run_seq(input int unsigned lat, input int block);
        longint b;
        repeat ($urandom_range(0, 5)) @(posedge clk);
        @(posedge clk);
        #1;
        slave_lat = lat;
        ack_block = block;
        ack_base  = n_acked;
        b = cyc_n + RESET_WAIT + 1;
        for (int i = 0; i < N_ENT; i++) begin
            if (block >= 0 && i == block) begin
                pred_err = b + ACK_TIMEOUT;
                break;
            end
            sb.push_back('{adr: DFII_BASE + tbl_off[i], dat: tbl_val[i], idx: i, ack_cyc: b + lat});
            b = b + lat + 1 + ((tbl_wait[i] > 1) ? tbl_wait[i] : 1);
        end
        pred_done = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int unsigned k;
        k = 0;
        @(negedge clk);
        while (!done && k < 6000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_done_cycle"}, cyc_n, pred_done);
        check({tag, "_busy_err_step"}, {busy, error, step}, {1'b0, 1'b0, 5'd28});
        check({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic wait_step(input int unsigned s);
        int unsigned k;
        k = 0;
        @(negedge clk);
        while (!(step == 5'(s) && wb_cyc) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("reach_step", step, s);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_table();
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wb", {wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_w}, '0);
        check("rst_status", {busy, done, error, step}, '0);
        @(posedge clk);
        #1 rst = 1'b0;

        // zero-latency slave, then spurious acks while in DONE
        run_seq(0, -1);
        wait_done("lat0");
        ack_force = 1'b1;
        repeat (4) @(negedge clk);
        check("spurious_ack", {done, busy, wb_cyc, error, step}, {1'b1, 1'b0, 1'b0, 1'b0, 5'd28});
        ack_force = 1'b0;

        // slave acking 3 cycles after strobe
        run_seq(3, -1);
        wait_done("lat3");

        // random latency with start pulses while busy
        run_seq($urandom_range(1, 4), -1);
        repeat (3) begin
            repeat ($urandom_range(50, 400)) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_done("latrnd");

        // slave never acks step 5
        run_seq(0, 5);
        @(negedge clk);
        for (int k = 0; k < 5000 && cyc_n < pred_err - 1; k++) @(negedge clk);
        check("pre_timeout", {wb_cyc, error}, 2'b10);
        @(negedge clk);
        check("timeout_error", {error, busy, done}, 3'b100);
        check("timeout_step", step, 5);
        check("timeout_cyc", {wb_cyc, wb_stb}, 2'b00);
        check("timeout_sb", sb.size(), 0);

        // restart from ERROR; start while busy at step 12 is ignored
        run_seq(0, -1);
        @(negedge clk);
        check("restart", {error, busy, done, step}, {1'b0, 1'b1, 1'b0, 5'd0});
        wait_step(12);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("busy_start");

        // reset in REQ at step 10
        run_seq(3, -1);
        wait_step(10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req_bus", {wb_cyc, wb_stb, busy}, 3'b000);
        check("rst_req_step", step, 0);
        sb.delete();
        rst = 1'b0;

        // recovery after mid-sequence reset
        run_seq($urandom_range(0, 2), -1);
        wait_done("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
